os_generator: RTL and testbench
===============================

Name: os_generator

Overview:
- Ordered-set generator that sits directly downstream of the TX LTSSM and feeds the TX data mux and the PIPE TX interface.
- On a Start request it latches the TS1, TS2 or IDLE request and its field values.
- It then emits one complete 16-symbol ordered set on every configured lane, across the PIPE data width.
- It reports Busy while the set is in flight and pulses Finish on the last beat; the LTSSM counts those pulses.

Parameters:
- LANESNUMBER, 16, number of lanes driven.
- MAXPIPEWIDTH, 32, per-lane bus slice width in bits.
- PIPEWIDTH, 8, active per-lane width in bits; legal values are 8, 16 and 32.
- N_FTS, 8'hFF, value sent in symbol 3 of TS1/TS2.

Ports:
- Pclk  in  1  clock.
- Reset  in  1  synchronous, active-low.
- Start  in  1  request to send one ordered set.
- OSType  in  2  00 TS1, 01 TS2, 10 IDLE, 11 reserved.
- LaneNumber  in  2  00 PAD, 01 sequential (lane i sends i), 1x PAD.
- LinkNumber  in  8  0 sends PAD; any other value is sent as data.
- Rate  in  3  highest supported generation, 1..5.
- Loopback  in  1  training-control loopback bit.
- Busy  out  1  ordered set in progress.
- Finish  out  1  one-cycle pulse on the last beat.
- TxData  out  LANESNUMBER*MAXPIPEWIDTH  lane i occupies slice [i*MAXPIPEWIDTH +: MAXPIPEWIDTH].
- TxDataK  out  LANESNUMBER*MAXPIPEWIDTH/8  one K flag per symbol byte.
- TxDataValid  out  1  TxData holds a valid beat.

Behaviour:
- Reset (Reset=0 at a rising edge): state IDLE; Busy, Finish, TxDataValid, TxData, TxDataK and the beat counter all 0. Reset aborts any in-flight set with no Finish.
- Geometry: SPB = PIPEWIDTH/8 symbols per beat. BEATS = 16/SPB, giving 16, 8 or 4 beats.
  - Symbol s of the set goes to beat s/SPB, byte (s mod SPB) of each lane slice; byte 0 (bits [7:0]) is transmitted first.
  - Slice bits at PIPEWIDTH and above are 0.
- States: IDLE and SEND.
  - IDLE: Start=1 with OSType != 11 latches all inputs, clears the beat counter and moves to SEND.
  - Start with OSType=11 is ignored.
  - Start while Busy=1 is ignored, including in the Finish cycle.
  - Latched fields hold constant for the whole set; input changes mid-set have no effect.
- Timing, with Start sampled at edge k:
  - Cycles k+1 .. k+BEATS: Busy=1 and TxDataValid=1, carrying beats 0..BEATS-1.
  - Cycle k+BEATS: Finish=1.
  - Cycle k+BEATS+1: Busy=0 and TxDataValid=0 unless a new Start was accepted.
  - A Start sampled in cycle k+BEATS+1 gives a one-beat gap between sets.
- TS1/TS2 symbols, per lane:
  - Symbol 0: COM 8'hBC, K=1.
  - Symbol 1: Link. LinkNumber=0 sends PAD 8'hF7 with K=1; otherwise LinkNumber with K=0.
  - Symbol 2: Lane. Code 01 sends lane index i with K=0; otherwise PAD 8'hF7 with K=1.
  - Symbol 3: N_FTS.
  - Symbol 4: rate ID.
    - bit1 = 1.
    - bit2 = (Rate>=2), bit3 = (Rate>=3), bit4 = (Rate>=4), bit5 = (Rate>=5).
    - All other bits 0.
    - Rate values of 0 or 1 both produce 8'h02; values above 5 produce the same field as Rate=5.
  - Symbol 5: training control, 8'h04 when Loopback=1, else 8'h00.
  - Symbols 6..15: 8'h4A for TS1, 8'h45 for TS2.
  - Symbols 1..15 have K=0 except PAD symbols.
- IDLE: 16 symbols of 8'h00 with K=0 on every lane; Busy, Finish and timing identical to TS1/TS2.
- Outside SEND: TxData=0, TxDataK=0, TxDataValid=0.

Test Plan:
- PIPEWIDTH=8, Start with TS1, LinkNumber=1, LaneNumber=01, Rate=1, Loopback=0 -> 16 valid beats. Lane 3 sequence is BC(K),01,03,FF,02,00, then 4A×10. Finish is high only on beat 15; Busy is low on the next cycle.
- TS2, LinkNumber=0, LaneNumber=00, Rate=5, Loopback=1 -> symbols 1 and 2 are F7 with K=1. Symbol 4 = 8'h3E, symbol 5 = 8'h04, symbols 6..15 = 45.
- PIPEWIDTH=32, IDLE -> 4 beats. Each lane slice is 32'h0 with K=4'h0; Finish on beat 3.
- Start held high continuously during a TS1 -> inputs changed mid-set are ignored. The next set starts exactly one cycle after Busy falls, giving a one-gap cadence over 3 sets with 3 Finish pulses.
- Reset asserted at beat 7 -> the next cycle has all outputs 0 and no Finish. After release, a new Start produces a full set.
- OSType=11 with Start=1 -> Busy, TxDataValid and Finish stay 0.

Source files
------------

// File: rtl/os_generator.sv
// Ordered-set generator: on Start, latches a TS1/TS2/IDLE request and streams one
// 16-symbol ordered set on every lane across the PIPE width, pulsing Finish on the last beat.

module os_lane #(
  parameter int         LANE         = 0,
  parameter int         MAXPIPEWIDTH = 32,
  parameter int         PIPEWIDTH    = 8,
  parameter logic [7:0] N_FTS        = 8'hFF
) (
  input  logic                      en_i,
  input  logic [3:0]                beat_i,
  input  logic [1:0]                os_i,
  input  logic [1:0]                lane_i,
  input  logic [7:0]                link_i,
  input  logic [7:0]                rate_id_i,
  input  logic                      lb_i,
  output logic [MAXPIPEWIDTH-1:0]   data_o,
  output logic [MAXPIPEWIDTH/8-1:0] k_o
);
  localparam int SPB = PIPEWIDTH / 8;
  localparam int NB  = MAXPIPEWIDTH / 8;

  // Returns {K, symbol} for symbol index s of the set on this lane.
  function automatic logic [8:0] sym_f(input logic [3:0] s, input logic [1:0] os,
                                       input logic [1:0] ln, input logic [7:0] lk,
                                       input logic [7:0] rid, input logic lb);
    if (os == 2'b10) return 9'h000;
    case (s)
      4'd0:    return 9'h1BC;
      4'd1:    return (lk == 8'h00) ? 9'h1F7 : {1'b0, lk};
      4'd2:    return (ln == 2'b01) ? {1'b0, 8'(LANE)} : 9'h1F7;
      4'd3:    return {1'b0, N_FTS};
      4'd4:    return {1'b0, rid};
      4'd5:    return lb ? 9'h004 : 9'h000;
      default: return (os == 2'b00) ? 9'h04A : 9'h045;
    endcase
  endfunction

  always_comb begin
    data_o = '0;
    k_o    = '0;
    for (int j = 0; j < NB; j++) begin
      if (en_i && j < SPB)
        {k_o[j], data_o[j*8 +: 8]} = sym_f(4'(int'(beat_i) * SPB + j), os_i, lane_i,
                                           link_i, rate_id_i, lb_i);
    end
  end
endmodule

module os_generator #(
  parameter int         LANESNUMBER  = 16,
  parameter int         MAXPIPEWIDTH = 32,
  parameter int         PIPEWIDTH    = 8,
  parameter logic [7:0] N_FTS        = 8'hFF
) (
  input  logic                                  Pclk,
  input  logic                                  Reset,
  input  logic                                  Start,
  input  logic [1:0]                            OSType,
  input  logic [1:0]                            LaneNumber,
  input  logic [7:0]                            LinkNumber,
  input  logic [2:0]                            Rate,
  input  logic                                  Loopback,
  output logic                                  Busy,
  output logic                                  Finish,
  output logic [LANESNUMBER*MAXPIPEWIDTH-1:0]   TxData,
  output logic [LANESNUMBER*MAXPIPEWIDTH/8-1:0] TxDataK,
  output logic                                  TxDataValid
);
  localparam int         SPB   = PIPEWIDTH / 8;
  localparam int         BEATS = 16 / SPB;
  localparam logic [3:0] LAST  = 4'(BEATS - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  beat_q, beat_d;
  logic [1:0]  os_q, os_d, lane_q, lane_d;
  logic [7:0]  link_q, link_d;
  logic [2:0]  rate_q, rate_d;
  logic        lb_q, lb_d;
  logic [7:0]  rate_id;

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      os_q    <= '0;
      lane_q  <= '0;
      link_q  <= '0;
      rate_q  <= '0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      os_q    <= os_d;
      lane_q  <= lane_d;
      link_q  <= link_d;
      rate_q  <= rate_d;
      lb_q    <= lb_d;
    end
  end

  // Start is only looked at in IDLE, so a request during any SEND beat is dropped.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    os_d    = os_q;
    lane_d  = lane_q;
    link_d  = link_q;
    rate_d  = rate_q;
    lb_d    = lb_q;
    case (state_q)
      S_IDLE: begin
        if (Start && OSType != 2'b11) begin
          state_d = S_SEND;
          beat_d  = '0;
          os_d    = OSType;
          lane_d  = LaneNumber;
          link_d  = LinkNumber;
          rate_d  = Rate;
          lb_d    = Loopback;
        end
      end
      S_SEND: begin
        if (beat_q == LAST) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Rates 0/1 collapse to gen1 only; anything past 5 saturates at gen5.
  assign rate_id = {2'b00, rate_q >= 3'd5, rate_q >= 3'd4, rate_q >= 3'd3,
                    rate_q >= 3'd2, 1'b1, 1'b0};

  assign Busy        = (state_q == S_SEND);
  assign TxDataValid = Busy;
  assign Finish      = Busy && (beat_q == LAST);

  for (genvar i = 0; i < LANESNUMBER; i++) begin : g_lane
    os_lane #(
      .LANE(i), .MAXPIPEWIDTH(MAXPIPEWIDTH), .PIPEWIDTH(PIPEWIDTH), .N_FTS(N_FTS)
    ) u_lane (
      .en_i      (Busy),
      .beat_i    (beat_q),
      .os_i      (os_q),
      .lane_i    (lane_q),
      .link_i    (link_q),
      .rate_id_i (rate_id),
      .lb_i      (lb_q),
      .data_o    (TxData[i*MAXPIPEWIDTH +: MAXPIPEWIDTH]),
      .k_o       (TxDataK[i*(MAXPIPEWIDTH/8) +: MAXPIPEWIDTH/8])
    );
  end
endmodule

// File: tb/tb_os_generator.sv
// Scoreboard bench for os_generator: one 8-bit-wide and one 32-bit-wide instance,
// expected beats queued at request time and popped by per-instance monitors.

module tb_os_generator;
  logic         Pclk = 1'b0;
  logic         Reset = 1'b0;
  logic         start_a = 1'b0, start_b = 1'b0;
  logic [1:0]   os = 2'b00, lnum = 2'b00;
  logic [7:0]   link = 8'h00;
  logic [2:0]   rate = 3'd0;
  logic         lb = 1'b0;
  logic         busy_a, fin_a, vld_a, busy_b, fin_b, vld_b;
  logic [511:0] d_a, d_b;
  logic [63:0]  k_a, k_b;

  always #5 Pclk = ~Pclk;

  os_generator #(.LANESNUMBER(16), .MAXPIPEWIDTH(32), .PIPEWIDTH(8), .N_FTS(8'hFF)) dut_a (
    .Pclk(Pclk), .Reset(Reset), .Start(start_a), .OSType(os), .LaneNumber(lnum),
    .LinkNumber(link), .Rate(rate), .Loopback(lb), .Busy(busy_a), .Finish(fin_a),
    .TxData(d_a), .TxDataK(k_a), .TxDataValid(vld_a));

  os_generator #(.LANESNUMBER(16), .MAXPIPEWIDTH(32), .PIPEWIDTH(32), .N_FTS(8'hFF)) dut_b (
    .Pclk(Pclk), .Reset(Reset), .Start(start_b), .OSType(os), .LaneNumber(lnum),
    .LinkNumber(link), .Rate(rate), .Loopback(lb), .Busy(busy_b), .Finish(fin_b),
    .TxData(d_b), .TxDataK(k_b), .TxDataValid(vld_b));

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic         fin;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    checks = 0, failures = 0, nfin_a = 0, nfin_b = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Hand-written symbol table: {K, byte} for symbol s on lane `lane`.
  function automatic logic [8:0] exp_sym(int s, int lane, logic [1:0] o, logic [1:0] ln,
                                         logic [7:0] lk, logic [2:0] r, logic l);
    logic [7:0] rid;
    case (r)
      3'd0, 3'd1: rid = 8'h02;
      3'd2:       rid = 8'h06;
      3'd3:       rid = 8'h0E;
      3'd4:       rid = 8'h1E;
      default:    rid = 8'h3E;
    endcase
    if (o == 2'b10) return 9'h000;
    case (s)
      0:       return 9'h1BC;
      1:       return (lk == 8'h00) ? 9'h1F7 : {1'b0, lk};
      2:       return (ln == 2'b01) ? {1'b0, 8'(lane)} : 9'h1F7;
      3:       return 9'h0FF;
      4:       return {1'b0, rid};
      5:       return l ? 9'h004 : 9'h000;
      default: return (o == 2'b00) ? 9'h04A : 9'h045;
    endcase
  endfunction

  task automatic push_set(input bit to_b, input int pw);
    int    spb;
    beat_t x;
    logic [8:0] sv;
    spb = pw / 8;
    for (int b = 0; b < 16 / spb; b++) begin
      x = '0;
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < spb; j++) begin
          sv = exp_sym(b * spb + j, i, os, lnum, link, rate, lb);
          x.d[i*32 + j*8 +: 8] = sv[7:0];
          x.k[i*4 + j]         = sv[8];
        end
      x.fin = (b == 16 / spb - 1);
      if (to_b) qb.push_back(x); else qa.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] o, input logic [1:0] ln, input logic [7:0] lk,
                        input logic [2:0] r, input logic l);
    os = o; lnum = ln; link = lk; rate = r; lb = l;
  endtask

  task automatic send(input bit to_b, input logic [1:0] o, input logic [1:0] ln,
                      input logic [7:0] lk, input logic [2:0] r, input logic l);
    int pw;
    pw = to_b ? 32 : 8;
    set_in(o, ln, lk, r, l);
    push_set(to_b, pw);
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (128 / pw + 2) tick();
  endtask

  always @(negedge Pclk) begin : mon_a
    beat_t e;
    if (mon_en) begin
      if (vld_a) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL A.unexpected_beat got=valid exp=idle");
        end else begin
          e = qa.pop_front();
          chk("A.data", d_a, e.d);
          chk("A.k", 512'(k_a), 512'(e.k));
          chk("A.fin_busy", 512'({fin_a, busy_a}), 512'({e.fin, 1'b1}));
        end
      end else begin
        chk("A.idle_outputs", 512'({fin_a, busy_a, |d_a, |k_a}), 512'(0));
      end
      if (fin_a) nfin_a++;
    end
  end

  always @(negedge Pclk) begin : mon_b
    beat_t e;
    if (mon_en) begin
      if (vld_b) begin
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL B.unexpected_beat got=valid exp=idle");
        end else begin
          e = qb.pop_front();
          chk("B.data", d_b, e.d);
          chk("B.k", 512'(k_b), 512'(e.k));
          chk("B.fin_busy", 512'({fin_b, busy_b}), 512'({e.fin, 1'b1}));
        end
      end else begin
        chk("B.idle_outputs", 512'({fin_b, busy_b, |d_b, |k_b}), 512'(0));
      end
      if (fin_b) nfin_b++;
    end
  end

  initial begin
    int cap;
    Reset = 1'b0;
    tick();
    mon_en = 1'b1;
    repeat (2) tick();
    Reset = 1'b1;
    tick();

    // TS1 sequential lanes, then TS2 all-PAD gen5 loopback, then PAD/rate corners
    send(1'b0, 2'b00, 2'b01, 8'h01, 3'd1, 1'b0);
    send(1'b0, 2'b01, 2'b00, 8'h00, 3'd5, 1'b1);
    send(1'b0, 2'b00, 2'b11, 8'h5A, 3'd3, 1'b0);
    send(1'b0, 2'b01, 2'b10, 8'hC3, 3'd7, 1'b0);
    send(1'b0, 2'b00, 2'b01, 8'h80, 3'd0, 1'b1);

    // Reserved type must not start anything
    set_in(2'b11, 2'b01, 8'h01, 3'd2, 1'b0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("A.reserved_busy", 512'({busy_a, vld_a, fin_a}), 512'(0));
    repeat (20) tick();

    // Start held high: three sets with a single idle cycle between them
    cap = nfin_a;
    set_in(2'b00, 2'b01, 8'h11, 3'd2, 1'b0); push_set(1'b0, 8);
    set_in(2'b01, 2'b00, 8'h22, 3'd4, 1'b1); push_set(1'b0, 8);
    set_in(2'b00, 2'b11, 8'h00, 3'd5, 1'b0); push_set(1'b0, 8);
    set_in(2'b00, 2'b01, 8'h11, 3'd2, 1'b0);
    start_a = 1'b1;
    tick();
    repeat (3) tick();
    set_in(2'b01, 2'b00, 8'h22, 3'd4, 1'b1);
    repeat (13) tick();
    chk("A.gap1_busy", 512'(busy_a), 512'(0));
    tick();
    chk("A.set2_busy", 512'(busy_a), 512'(1));
    repeat (3) tick();
    set_in(2'b00, 2'b11, 8'h00, 3'd5, 1'b0);
    repeat (13) tick();
    chk("A.gap2_busy", 512'(busy_a), 512'(0));
    tick();
    start_a = 1'b0;
    chk("A.set3_busy", 512'(busy_a), 512'(1));
    repeat (18) tick();
    chk("A.cadence_finish_count", 512'(nfin_a - cap), 512'(3));

    // Reset lands while beat 7 is on the bus
    set_in(2'b00, 2'b01, 8'h07, 3'd2, 1'b0);
    push_set(1'b0, 8);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cap = nfin_a;
    repeat (7) tick();
    Reset = 1'b0;
    tick();
    qa.delete();
    chk("A.reset_abort", 512'({busy_a, vld_a, fin_a, |d_a, |k_a}), 512'(0));
    tick();
    Reset = 1'b1;
    tick();
    chk("A.reset_no_finish", 512'(nfin_a - cap), 512'(0));
    send(1'b0, 2'b00, 2'b01, 8'h09, 3'd1, 1'b0);

    // 32-bit instance: IDLE set then a TS1
    cap = nfin_b;
    send(1'b1, 2'b10, 2'b01, 8'h01, 3'd1, 1'b0);
    send(1'b1, 2'b00, 2'b01, 8'h01, 3'd1, 1'b0);
    chk("B.finish_count", 512'(nfin_b - cap), 512'(2));

    chk("A.queue_drained", 512'(qa.size()), 512'(0));
    chk("B.queue_drained", 512'(qb.size()), 512'(0));
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
